// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI GNT# arbiter with unused-grant revocation and one-cycle turnaround.
// Define PCI_ARB_PARK_EN to park the bus on the last owner while no master requests.
module pci_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         bus_busy
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_TURN} state_t;
  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic [IW-1:0]  r_last, w_last_nxt, r_idx, w_idx_nxt, w_win, w_sel;
  logic [N_MASTERS-1:0] r_gnt_n, w_gnt_nxt;
  logic           r_busy, w_any, w_bus_idle, w_timeout, w_parked;
  logic [IW:0]    w_pick;
  // Walk last+N down to last+1 so the nearest requester after the last owner is kept.
  function automatic logic [IW:0] pick(input logic [N_MASTERS-1:0] rq, input logic [IW-1:0] last);
    pick = {1'b0, last};
    for (int k = N_MASTERS; k >= 1; k--)
      if (!rq[IW'((int'(last) + k) % N_MASTERS)]) pick = {1'b1, IW'((int'(last) + k) % N_MASTERS)};
  endfunction
  assign w_pick     = pick(req_n, r_last);
  assign w_any      = w_pick[IW];
  assign w_win      = w_pick[IW-1:0];
  assign w_bus_idle = frame_n & irdy_n;
  assign w_timeout  = r_timer == TW'(IDLE_TIMEOUT - 1);
`ifdef PCI_ARB_PARK_EN
  assign w_parked   = (r_state == S_IDLE) && !r_gnt_n[r_last];
`else
  assign w_parked   = 1'b0;
`endif
  assign w_sel      = w_parked ? r_last : w_win;
  assign gnt_n      = r_gnt_n;
  assign grant_idx  = r_idx;
  assign bus_busy   = r_busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_last  <= IW'(N_MASTERS - 1);
      r_idx   <= '0;
      r_gnt_n <= '1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt_n <= w_gnt_nxt;
      r_busy  <= w_state_nxt == S_BUSY;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_parked ? (!frame_n ? S_BUSY : !req_n[r_last] ? S_GRANT : w_any ? S_TURN : S_IDLE)
                                      : (w_any && w_bus_idle ? S_GRANT : S_IDLE);
      S_GRANT: w_state_nxt = !frame_n ? S_BUSY : (w_timeout || req_n[r_idx]) ? S_TURN : S_GRANT;
      S_BUSY:  w_state_nxt = w_bus_idle ? S_TURN : S_BUSY;
      S_TURN:  w_state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    w_gnt_nxt   = '1;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_timer_nxt = '0;
    if (w_state_nxt == S_GRANT) begin
      if (r_state == S_IDLE) begin
        w_idx_nxt  = w_sel;
        w_last_nxt = w_sel;
      end else
        w_timer_nxt = (&r_timer) ? r_timer : r_timer + 1'b1;
      w_gnt_nxt[w_idx_nxt] = 1'b0;
    end
`ifdef PCI_ARB_PARK_EN
    if (w_state_nxt == S_IDLE && !w_any) begin
      w_gnt_nxt[r_last] = 1'b0;
      w_idx_nxt         = r_last;
    end
`endif
  end
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed vector table plus hand sequences for timeout and reset mid-BUSY.
module tb_pci_arbiter;
  logic       clk = 1'b0, reset = 1'b1, frame_n = 1'b1, irdy_n = 1'b1;
  logic [3:0] req_n = '1, gnt_n;
  logic [1:0] grant_idx;
  logic       bus_busy;
  int         checks = 0, failures = 0, cnt;
  typedef struct {
    logic rst; logic [3:0] req; logic fr, ir;
    logic [3:0] gnt; logic [1:0] idx; logic busy;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  pci_arbiter #(.N_MASTERS(4), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n), .grant_idx(grant_idx), .bus_busy(bus_busy)
  );
  function automatic void add(logic r, logic [3:0] rq, logic f, logic i, logic [3:0] g, logic [1:0] ix, logic b);
    vec_t v;
    v = '{r, rq, f, i, g, ix, b};
    tbl.push_back(v);
  endfunction
  task automatic drive(logic r, logic [3:0] rq, logic f, logic i);
    reset = r; req_n = rq; frame_n = f; irdy_n = i;
    @(posedge clk); #1;
  endtask
  task automatic check(string nm, logic [3:0] g, logic [1:0] ix, logic b);
    checks++;
    if (gnt_n !== g || grant_idx !== ix || bus_busy !== b) begin
      failures++;
      $display("FAIL %s: got gnt_n=%b idx=%0d busy=%b, want gnt_n=%b idx=%0d busy=%b",
               nm, gnt_n, grant_idx, bus_busy, g, ix, b);
    end
  endtask
  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
`ifdef PCI_ARB_PARK_EN
    add(1, 4'b1111, 1, 1, 4'b1111, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0111, 3, 0);
    add(0, 4'b1101, 1, 1, 4'b1111, 3, 0);
    add(0, 4'b1101, 1, 1, 4'b1111, 3, 0);
    add(0, 4'b1101, 1, 1, 4'b1101, 1, 0);
    add(0, 4'b1111, 0, 1, 4'b1111, 1, 1);
    add(0, 4'b1111, 1, 1, 4'b1111, 1, 0);
    add(0, 4'b1111, 1, 1, 4'b1101, 1, 0);
    add(0, 4'b1111, 1, 1, 4'b1101, 1, 0);
    add(0, 4'b0111, 1, 1, 4'b1111, 1, 0);
    add(0, 4'b0111, 1, 1, 4'b1111, 1, 0);
    add(0, 4'b0111, 1, 1, 4'b0111, 3, 0);
    add(0, 4'b1111, 1, 1, 4'b1111, 3, 0);
    add(0, 4'b1111, 1, 1, 4'b0111, 3, 0);
    add(0, 4'b1111, 0, 1, 4'b1111, 3, 1);
    add(0, 4'b1111, 1, 1, 4'b1111, 3, 0);
`else
    add(1, 4'b1111, 1, 1, 4'b1111, 0, 0);
    add(0, 4'b1110, 0, 1, 4'b1111, 0, 0);
    add(0, 4'b1110, 1, 0, 4'b1111, 0, 0);
    add(0, 4'b1110, 1, 1, 4'b1110, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b1111, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b1111, 0, 0);
    add(0, 4'b1101, 1, 1, 4'b1101, 1, 0);
    add(0, 4'b1101, 0, 1, 4'b1111, 1, 1);
    add(0, 4'b1111, 0, 0, 4'b1111, 1, 1);
    add(0, 4'b1111, 1, 1, 4'b1111, 1, 0);
    add(0, 4'b1111, 1, 1, 4'b1111, 1, 0);
    add(0, 4'b1011, 1, 1, 4'b1011, 2, 0);
    add(0, 4'b1111, 0, 1, 4'b1111, 2, 1);
    add(0, 4'b1111, 1, 1, 4'b1111, 2, 0);
    add(0, 4'b1111, 1, 1, 4'b1111, 2, 0);
    add(1, 4'b0000, 1, 1, 4'b1111, 0, 0);
    foreach (order[j]) begin
      add(0, 4'b0000, 1, 1, ~(4'b0001 << order[j]), 2'(order[j]), 0);
      repeat (3) add(0, 4'b0000, 0, 0, 4'b1111, 2'(order[j]), 1);
      add(0, 4'b0000, 1, 1, 4'b1111, 2'(order[j]), 0);
      add(0, 4'b0000, 1, 1, 4'b1111, 2'(order[j]), 0);
    end
`endif
    drive(1, 4'($urandom), 1, 1);
    drive(1, 4'($urandom), 1, 1);
    check("reset", 4'b1111, 0, 0);
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].req, tbl[k].fr, tbl[k].ir);
      check($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].idx, tbl[k].busy);
    end
`ifndef PCI_ARB_PARK_EN
    drive(1, 4'b1111, 1, 1);
    drive(0, 4'b1011, 1, 1);
    check("timeout_grant", 4'b1011, 2, 0);
    cnt = 1;
    req_n = 4'b0011;
    for (int c = 0; c < 40 && gnt_n == 4'b1011; c++) begin
      @(posedge clk); #1;
      if (gnt_n == 4'b1011) cnt++;
    end
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL timeout_len: got %0d grant cycles, want 16", cnt);
    end
    check("timeout_turn", 4'b1111, 2, 0);
    drive(0, 4'b0011, 1, 1);
    check("timeout_idle", 4'b1111, 2, 0);
    drive(0, 4'b0011, 1, 1);
    check("timeout_next", 4'b0111, 3, 0);
    drive(0, 4'b0011, 0, 1);
    check("midbusy_busy", 4'b1111, 3, 1);
    drive(1, 4'b0011, 0, 0);
    check("midbusy_reset", 4'b1111, 0, 0);
    drive(0, 4'b1110, 0, 1);
    check("midbusy_idle", 4'b1111, 0, 0);
    drive(0, 4'b1110, 1, 1);
    check("midbusy_regrant", 4'b1110, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
